// File: rtl/output_wrapper_pkg.sv
// Shared definitions for the output wrapper: FSM encoding, byte width and
// counter sizing.
package output_wrapper_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte counter width; never narrower than one bit.
    function automatic int cnt_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/output_wrapper_cu.sv
// Output wrapper controller: IDLE -> SEND (one byte per accepted handshake)
// -> DONE (single-cycle done pulse) -> IDLE.
module output_wrapper_cu
    import output_wrapper_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic res_valid_i,
    input  logic out_ready_i,
    input  logic last_i,
    output logic load_o,
    output logic shift_o,
    output logic out_valid_o,
    output logic busy_o,
    output logic done_o
);

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Bus-facing outputs depend on state_q only, so no input reaches an
    // output combinationally.
    always_comb begin
        state_d     = state_q;
        load_o      = 1'b0;
        shift_o     = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (res_valid_i) begin
                    load_o  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    shift_o = 1'b1;
                    if (last_i) state_d = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/output_wrapper_dp.sv
// Output wrapper datapath: result shift register, byte counter and
// last-byte flag.
module output_wrapper_dp
    import output_wrapper_pkg::*;
#(
    parameter  int W  = 16,
    localparam int NB = W / BYTE_W,
    localparam int CW = cnt_w(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [W-1:0]      result_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              last_o
);

    logic [W-1:0]  rreg_q, rreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        rreg_d = rreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            rreg_d = result_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            // LSB first: the next byte drops into the low lane.
            rreg_d = {{BYTE_W{1'b0}}, rreg_q[W-1:BYTE_W]};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            rreg_q <= rreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign byte_o = rreg_q[BYTE_W-1:0];
    assign last_o = (cnt_q == CW'(NB - 1));

endmodule

// File: rtl/output_wrapper.sv
// Output wrapper top: serializes a W-bit result onto the 8-bit bus, LSB first,
// with valid/ready pacing and a done pulse.
module output_wrapper
    import output_wrapper_pkg::*;
#(
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    input  logic [W-1:0]      Result,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] Bus_out,
    output logic              busy,
    output logic              done
);

    logic load, shift, last;

    output_wrapper_dp #(.W(W)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .shift_i  (shift),
        .result_i (Result),
        .byte_o   (Bus_out),
        .last_o   (last)
    );

    output_wrapper_cu u_cu (
        .clk         (clk),
        .rst         (rst),
        .res_valid_i (res_valid),
        .out_ready_i (out_ready),
        .last_i      (last),
        .load_o      (load),
        .shift_o     (shift),
        .out_valid_o (out_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

endmodule
